lzc_stream: RTL and testbench
=============================

Name: lzc_stream

Overview:
- Parametrised streaming leading-zero/leading-one counter. Successor to the fixed-width LZC.
- Accepts a vector of WORDS words of WIDTH bits each, MSB word first, one word per accepted beat.
- Counts leading zeros (MODE=0) or leading ones (MODE=1) across the whole concatenated vector.
- Emits the count through a valid/ready output handshake with backpressure. Sits between the operand-streaming front end and the normaliser.

Parameters:
- WIDTH, 8: bits per input word (>=1).
- WORDS, 4: words per vector (>=1).
- CW, $clog2(WIDTH*WORDS+1): count width. Local, derived; not overridable.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IVALID  input  1  input word valid.
- IREADY  output  1  block can accept a word this cycle.
- DATA  input  WIDTH  input word; the MSB word of the vector arrives first.
- MODE  input  1  0 = count leading zeros, 1 = count leading ones; sampled on the first word of a vector only.
- OVALID  output  1  result valid; held until accepted.
- OREADY  input  1  downstream accepts the result.
- ZEROS  output  CW  leading count of the vector.

Behaviour:
- Reset, asynchronous, while RST_N=0: state=IDLE, word counter=0, accumulator=0, latched mode=0, found flag=0, OVALID=0, ZEROS=0, IREADY=0. IREADY rises on the first CLK edge after RST_N deasserts.
- Beat accepted when IVALID && IREADY.
- IREADY = (state!=DONE) || OREADY. This allows back-to-back vectors with zero bubble.
- States:
  - IDLE: waiting for the first word. An accepted beat latches MODE, computes the in-word count and sets the counter to 1. Next state is ACC, or DONE if WORDS==1.
  - ACC: each accepted beat is processed.
    - If found=0: accumulator += in-word count. Set found=1 when the word contains a non-matching bit.
    - If found=1: the word is consumed and the count is unchanged.
    - Counter increments. On the WORDS-th beat, go to DONE.
  - DONE: OVALID=1 and ZEROS=accumulator, both stable while OREADY=0; all DATA and IVALID are ignored.
    - On OREADY=1 the result is released.
    - If an accepted first word arrives in the same cycle, it starts the next vector: go to ACC, or stay in DONE with the new single-word result if WORDS==1.
    - Otherwise go to IDLE.
- In-word count: number of leading bits equal to the latched mode, range 0..WIDTH. The current word's count is computed combinationally and added in the same cycle.
- Latency: OVALID asserts on the cycle after the last word is accepted.
- IVALID gaps: any number of idle cycles mid-vector; the count is unaffected.
- Changes to MODE mid-vector are ignored.
- Maximum count is WIDTH*WORDS; CW guarantees no overflow and no wrap.
- Reset mid-vector: the partial vector is discarded and all state returns to reset values.

Optional Feature:
- Macro: LZC_ALLMATCH_EN.
- When defined:
  - Adds output port ALLMATCH (1 bit), reset 0.
  - Valid with OVALID and held with it.
  - High when the entire vector matched the mode, i.e. ZEROS==WIDTH*WORDS.
  - Registered; asserts in the same cycle as OVALID.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, WORDS=4, MODE=0, words 0x00,0x00,0x10,0xFF, continuous IVALID, OREADY=1 → OVALID one cycle after the 4th beat, ZEROS=19, ALLMATCH=0.
- MODE=0, words 0x00 ×4 → ZEROS=32, ALLMATCH=1. Then MODE=1, words 0xFF,0xF0,0xFF,0xFF → ZEROS=12.
- IVALID gaps: 0x00, 2 idle cycles, 0x01, 3 idle cycles, 0xFF, 0x00 → ZEROS=15. Toggling MODE during the gaps has no effect.
- Backpressure: hold OREADY=0 for 3 cycles after OVALID → ZEROS and OVALID stable, IREADY=0, offered words not consumed. Then raise OREADY with the next vector's first word → zero-bubble restart, and the second result is correct.
- Reset mid-vector: after 2 beats pull RST_N low asynchronously mid-cycle → OVALID/ZEROS/IREADY drop to 0 immediately. A fresh 4-word vector after release gives the correct count with no residue.
- WORDS=1, WIDTH=8: back-to-back words 0x80, 0x00, 0x01 with OREADY=1 → results 0, 8, 7 on consecutive cycles.

Source files
------------

// File: rtl/lzc_stream.sv
// rtl/lzc_stream.sv - streaming leading-zero/leading-one counter over WORDS words of WIDTH bits.
// Optional ALLMATCH output enabled by defining LZC_ALLMATCH_EN.
module lzc_stream #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4,
   localparam int CW = $clog2(WIDTH*WORDS+1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IVALID,
   output logic             IREADY,
   input  logic [WIDTH-1:0] DATA,
   input  logic             MODE,
   output logic             OVALID,
   input  logic             OREADY,
`ifdef LZC_ALLMATCH_EN
   output logic             ALLMATCH,
`endif
   output logic [CW-1:0]    ZEROS
);

   localparam int CNTW = $clog2(WORDS+1);
   localparam logic [CW-1:0] TOTAL = CW'(WIDTH*WORDS);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t          state;
   logic [CNTW-1:0] cnt;
   logic [CW-1:0]   acc;
   logic            mode_q;
   logic            found;
   logic            ready_q;
   logic            ovalid_q;
   logic            allmatch_q;

   logic            beat;
   logic            first;
   logic            cur_mode;
   logic            hit;
   logic [CW-1:0]   wcnt;
   logic [CW-1:0]   acc_next;
   logic            last;

   // The first word of a vector uses the live MODE; later words use the latched one.
   always_comb begin
      first    = (state != ACC);
      cur_mode = first ? MODE : mode_q;
      wcnt     = '0;
      hit      = 1'b0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (!hit) begin
            if (DATA[i] == cur_mode) wcnt = wcnt + CW'(1);
            else                     hit  = 1'b1;
         end
      end
      acc_next = found ? acc : (acc + wcnt);
      last     = (cnt == CNTW'(WORDS-1));
   end

   assign IREADY = ready_q && ((state != DONE) || OREADY);
   assign beat   = IVALID && IREADY;
   assign OVALID = ovalid_q;
   assign ZEROS  = acc;
`ifdef LZC_ALLMATCH_EN
   assign ALLMATCH = allmatch_q;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         acc        <= '0;
         mode_q     <= 1'b0;
         found      <= 1'b0;
         ready_q    <= 1'b0;
         ovalid_q   <= 1'b0;
         allmatch_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (state == ACC) begin
            if (beat) begin
               acc   <= acc_next;
               found <= found | hit;
               cnt   <= cnt + CNTW'(1);
               if (last) begin
                  state      <= DONE;
                  ovalid_q   <= 1'b1;
                  allmatch_q <= (acc_next == TOTAL);
               end
            end
         end else if ((state == IDLE) || OREADY) begin
            // Releasing a result and starting the next vector can share one cycle.
            if (beat) begin
               mode_q <= MODE;
               acc    <= wcnt;
               found  <= hit;
               cnt    <= CNTW'(1);
               if (WORDS == 1) begin
                  state      <= DONE;
                  ovalid_q   <= 1'b1;
                  allmatch_q <= (wcnt == TOTAL);
               end else begin
                  state      <= ACC;
                  ovalid_q   <= 1'b0;
                  allmatch_q <= 1'b0;
               end
            end else begin
               state      <= IDLE;
               ovalid_q   <= 1'b0;
               allmatch_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_lzc_stream.sv
// tb/tb_lzc_stream.sv - self-checking bench for lzc_stream (WORDS=4 and WORDS=1 instances).
// Optional ALLMATCH checks follow LZC_ALLMATCH_EN.
module tb_lzc_stream;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       IVALID, IREADY, MODE, OVALID, OREADY;
   logic [7:0] DATA;
   logic [5:0] ZEROS;
   logic       iv1, ir1, mode1, ov1, or1;
   logic [7:0] d1;
   logic [3:0] z1;
`ifdef LZC_ALLMATCH_EN
   logic       ALLMATCH, am1;
`endif

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int q1[$];

   typedef struct packed {
      logic        mode;
      logic [31:0] words;
      logic [5:0]  exp;
   } vec_t;

   vec_t vecs [9];

   always #5 CLK = ~CLK;

   lzc_stream #(.WIDTH(8), .WORDS(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .IVALID(IVALID), .IREADY(IREADY), .DATA(DATA),
      .MODE(MODE), .OVALID(OVALID), .OREADY(OREADY),
`ifdef LZC_ALLMATCH_EN
      .ALLMATCH(ALLMATCH),
`endif
      .ZEROS(ZEROS));

   lzc_stream #(.WIDTH(8), .WORDS(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .IVALID(iv1), .IREADY(ir1), .DATA(d1),
      .MODE(mode1), .OVALID(ov1), .OREADY(or1),
`ifdef LZC_ALLMATCH_EN
      .ALLMATCH(am1),
`endif
      .ZEROS(z1));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboards: pop on every accepted result, sampled mid low phase.
   always @(negedge CLK) begin : mon4
      int e;
      #2;
      if (RST_N && OVALID && OREADY) begin
         if (exp_q.size() == 0) check("unexpected_result", int'(ZEROS), -1);
         else begin
            e = exp_q.pop_front();
            check("zeros", int'(ZEROS), e);
`ifdef LZC_ALLMATCH_EN
            check("allmatch", int'(ALLMATCH), int'(e == 32));
`endif
         end
      end
   end

   always @(negedge CLK) begin : mon1
      int e;
      #2;
      if (RST_N && ov1 && or1) begin
         if (q1.size() == 0) check("unexpected_result_w1", int'(z1), -1);
         else begin
            e = q1.pop_front();
            check("zeros_w1", int'(z1), e);
`ifdef LZC_ALLMATCH_EN
            check("allmatch_w1", int'(am1), int'(e == 8));
`endif
         end
      end
   end

   // Called just after a falling edge; returns just after a falling edge.
   task automatic send_word(input logic [7:0] d, input logic m);
      int tries = 0;
      DATA   = d;
      MODE   = m;
      IVALID = 1'b1;
      #1;
      while (!IREADY && tries < 20) begin
         @(negedge CLK);
         #1;
         tries++;
      end
      if (!IREADY) check("accept_timeout", 0, 1);
      else begin
         @(posedge CLK);
         @(negedge CLK);
      end
      IVALID = 1'b0;
   endtask

   // Later words carry the inverted mode to show it is ignored mid-vector.
   task automatic send_vec(input vec_t v);
      exp_q.push_back(int'(v.exp));
      for (int k = 0; k < 4; k++)
         send_word(v.words[31-8*k -: 8], (k == 0) ? v.mode : ~v.mode);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || q1.size() != 0) && n < 50) begin
         @(negedge CLK);
         n++;
      end
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0000_10FF, 6'd19};
      vecs[1] = '{1'b0, 32'h0000_0000, 6'd32};
      vecs[2] = '{1'b1, 32'hFFF0_FFFF, 6'd12};
      vecs[3] = '{1'b1, 32'h00FF_FFFF, 6'd0};
      vecs[4] = '{1'b1, 32'hFFFF_FFFF, 6'd32};
      vecs[5] = '{1'b0, 32'h8000_0000, 6'd0};
      vecs[6] = '{1'b0, 32'h0000_0001, 6'd31};
      vecs[7] = '{1'b1, 32'hFFFF_FFFE, 6'd31};
      vecs[8] = '{1'b0, 32'h01FF_FFFF, 6'd7};

      RST_N = 1'b0; IVALID = 1'b0; DATA = '0; MODE = 1'b0; OREADY = 1'b1;
      iv1 = 1'b0; d1 = '0; mode1 = 1'b0; or1 = 1'b1;
      #2;
      check("reset_ovalid", int'(OVALID), 0);
      check("reset_zeros", int'(ZEROS), 0);
      check("reset_iready", int'(IREADY), 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      #1;
      check("iready_before_edge", int'(IREADY), 0);
      @(negedge CLK);
      check("iready_after_edge", int'(IREADY), 1);

      send_vec(vecs[0]);
      #1;
      check("latency_ovalid", int'(OVALID), 1);
      @(negedge CLK);
      for (int i = 0; i < 9; i++) send_vec(vecs[i]);
      drain();

      // Gaps mid-vector with MODE toggling while idle.
      exp_q.push_back(15);
      send_word(8'h00, 1'b0);
      MODE = 1'b1; @(negedge CLK); MODE = 1'b0; @(negedge CLK);
      send_word(8'h01, 1'b1);
      MODE = 1'b1; @(negedge CLK); MODE = 1'b0; @(negedge CLK); MODE = 1'b1; @(negedge CLK);
      send_word(8'hFF, 1'b1);
      send_word(8'h00, 1'b0);
      drain();

      // Backpressure, then zero-bubble restart.
      OREADY = 1'b0;
      exp_q.push_back(19);
      send_word(8'h00, 1'b0); send_word(8'h00, 1'b1);
      send_word(8'h10, 1'b1); send_word(8'hFF, 1'b1);
      #1;
      check("bp_ovalid", int'(OVALID), 1);
      check("bp_zeros", int'(ZEROS), 19);
      check("bp_iready", int'(IREADY), 0);
      IVALID = 1'b1; DATA = 8'h00; MODE = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         #1;
         check("bp_hold_ovalid", int'(OVALID), 1);
         check("bp_hold_zeros", int'(ZEROS), 19);
         check("bp_hold_iready", int'(IREADY), 0);
      end
      @(negedge CLK);
      OREADY = 1'b1;
      #1;
      check("restart_iready", int'(IREADY), 1);
      send_vec(vecs[2]);
      drain();

      // Asynchronous reset after two beats.
      send_word(8'h00, 1'b0);
      send_word(8'h00, 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      check("midrst_ovalid", int'(OVALID), 0);
      check("midrst_zeros", int'(ZEROS), 0);
      check("midrst_iready", int'(IREADY), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      send_vec('{1'b0, 32'h0000_000F, 6'd28});
      drain();

      // Single-word vectors back to back.
      for (int i = 0; i < 3; i++) begin
         logic [23:0] w;
         w = 24'h80_00_01;
         d1 = w[23-8*i -: 8];
         iv1 = 1'b1;
         q1.push_back((i == 0) ? 0 : (i == 1) ? 8 : 7);
         #1;
         check("w1_iready", int'(ir1), 1);
         @(negedge CLK);
         #1;
         check("w1_ovalid", int'(ov1), 1);
      end
      iv1 = 1'b0;
      @(negedge CLK);
      #1;
      check("w1_ovalid_drop", int'(ov1), 0);
      drain();

      check("scoreboard_empty", exp_q.size(), 0);
      check("scoreboard_w1_empty", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
